// File: rtl/sum_accum5.sv
// ---------------------------------------------------------------------------
// sum_accum5
//   Collects blocks of N signed 5-bit samples (from the 5-bit signed adder's
//   sum) and presents, once per block, their exact signed total together with
//   the block's signed maximum and minimum sample.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        asynchronous, active-high reset
//   sum_in     5-bit signed sample
//   in_valid   sum_in carries a sample this cycle
//   in_ready   block accepts a sample this cycle (1 in ACCUM, 0 in HOLD)
//   acc_out    8-bit signed total of the last completed block
//   max_out    signed maximum sample of the last completed block
//   min_out    signed minimum sample of the last completed block
//   out_valid  block result is presented
//   out_ready  consumer takes the result this cycle
//   state      current FSM state (0 = ACCUM, 1 = HOLD), for observation only
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid=1 and ready=1 are both high; nothing else moves data. A producer's
// valid while ready=0 is ignored, and out_ready is ignored while out_valid=0.
// ---------------------------------------------------------------------------
module sum_accum5 #(
    parameter int N = 8  // samples per block, legal range 2..8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic signed [4:0] sum_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic signed [7:0] acc_out,
    output logic signed [4:0] max_out,
    output logic signed [4:0] min_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              state
);

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    localparam logic [3:0] LAST = 4'(N - 1);

    logic [0:0]        state_q;
    logic signed [7:0] acc;
    logic [3:0]        cnt;
    logic signed [4:0] run_max;
    logic signed [4:0] run_min;

    logic              xfer;
    logic              first;
    logic              last;
    logic signed [7:0] acc_next;
    logic signed [4:0] max_next;
    logic signed [4:0] min_next;

    // Moore output: ready depends on state only, never on in_valid.
    assign in_ready = (state_q == ACCUM);
    assign state    = state_q[0];
    assign xfer     = in_valid && in_ready;

    always_comb begin
        first    = (cnt == 4'd0);
        last     = (cnt == LAST);
        // 8 bits hold N*(-16) .. N*15 for N<=8, so the sum never wraps.
        acc_next = acc + {{3{sum_in[4]}}, sum_in};
        // The first sample of a block seeds max/min directly so the reset
        // value 0 never leaks into a block's result. Ties keep the old value.
        max_next = run_max;
        min_next = run_min;
        if (first) begin
            max_next = sum_in;
            min_next = sum_in;
        end else begin
            if (sum_in > run_max) max_next = sum_in;
            if (sum_in < run_min) min_next = sum_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            run_max   <= '0;
            run_min   <= '0;
            acc_out   <= '0;
            max_out   <= '0;
            min_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (xfer) begin
                        if (last) begin
                            // Result registers straight from the next-value
                            // logic, so out_valid rises one clock after the
                            // final transfer edge.
                            acc_out   <= acc_next;
                            max_out   <= max_next;
                            min_out   <= min_next;
                            out_valid <= 1'b1;
                            acc       <= '0;
                            cnt       <= '0;
                            run_max   <= max_next;
                            run_min   <= min_next;
                            state_q   <= HOLD;
                        end else begin
                            acc     <= acc_next;
                            cnt     <= cnt + 4'd1;
                            run_max <= max_next;
                            run_min <= min_next;
                        end
                    end
                end
                HOLD: begin
                    // Data outputs keep their values after the handshake
                    // until the next block completes.
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= ACCUM;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_sum_accum5.sv
// ---------------------------------------------------------------------------
// tb_sum_accum5
//   Directed bench for sum_accum5 (N = 8). An independent model tracks the
//   accept/hold state, running total, max and min; completed blocks push
//   {acc, max, min} into exp_q and are popped when the result is presented.
// ---------------------------------------------------------------------------
module tb_sum_accum5;

    localparam int N = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic signed [4:0] sum_in;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] acc_out;
    logic signed [4:0] max_out;
    logic signed [4:0] min_out;
    logic              out_valid;
    logic              out_ready;
    logic              state;

    sum_accum5 #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .sum_in    (sum_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .acc_out   (acc_out),
        .max_out   (max_out),
        .min_out   (min_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state     (state)
    );

    // ---- clock ------------------------------------------------------------
    always #5 clk = ~clk;

    // ---- scoreboard / model -----------------------------------------------
    logic [17:0] exp_q[$];     // {acc[7:0], max[4:0], min[4:0]}
    int          errors   = 0;
    int          n_checks = 0;

    int          m_cnt  = 0;
    int          m_sum  = 0;
    int          m_max  = 0;
    int          m_min  = 0;
    bit          m_hold = 1'b0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_sum  = 0;
        m_hold = 1'b0;
    endtask

    // Called at a negedge. Drives one cycle of input and updates the model
    // if the model says the sample is accepted.
    task automatic send(input logic signed [4:0] v, input bit valid);
        int vi;
        in_valid = valid;
        sum_in   = v;
        check("in_ready", {7'b0, in_ready}, {7'b0, !m_hold});
        check("out_valid_pre", {7'b0, out_valid}, {7'b0, m_hold});
        @(posedge clk);
        if (valid && !m_hold) begin
            vi = int'(v);
            if (m_cnt == 0) begin
                m_max = vi;
                m_min = vi;
            end else begin
                if (vi > m_max) m_max = vi;
                if (vi < m_min) m_min = vi;
            end
            m_sum += vi;
            m_cnt++;
            if (m_cnt == N) begin
                exp_q.push_back({8'(m_sum), 5'(m_max), 5'(m_min)});
                m_cnt  = 0;
                m_sum  = 0;
                m_hold = 1'b1;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_block(input logic signed [4:0] v);
        for (int i = 0; i < N; i++) send(v, 1'b1);
    endtask

    // Called at the negedge right after the final transfer edge: the result
    // must already be presented. Stalls for 'stall' cycles with in_valid
    // pulsing, then completes the output handshake.
    task automatic collect(input int stall);
        logic [17:0] e;
        check("out_valid_latency", {7'b0, out_valid}, 8'd1);
        if (exp_q.size() == 0) begin
            n_checks++;
            errors++;
            $error("FAIL scoreboard_empty: observed=0 expected=1 entries");
            return;
        end
        e = exp_q.pop_front();
        check("acc_out", acc_out, e[17:10]);
        check("max_out", {3'b0, $unsigned(max_out)}, {3'b0, e[9:5]});
        check("min_out", {3'b0, $unsigned(min_out)}, {3'b0, e[4:0]});
        out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            sum_in   = 5'($urandom_range(31, 0));
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            check("hold_out_valid", {7'b0, out_valid}, 8'd1);
            check("hold_in_ready", {7'b0, in_ready}, 8'd0);
            check("hold_acc", acc_out, e[17:10]);
            check("hold_max", {3'b0, $unsigned(max_out)}, {3'b0, e[9:5]});
            check("hold_min", {3'b0, $unsigned(min_out)}, {3'b0, e[4:0]});
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        m_hold = 1'b0;
        check("post_hs_out_valid", {7'b0, out_valid}, 8'd0);
        check("post_hs_in_ready", {7'b0, in_ready}, 8'd1);
        check("post_hs_acc_kept", acc_out, e[17:10]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_acc"}, acc_out, 8'd0);
        check({tag, "_max"}, {3'b0, $unsigned(max_out)}, 8'd0);
        check({tag, "_min"}, {3'b0, $unsigned(min_out)}, 8'd0);
        check({tag, "_out_valid"}, {7'b0, out_valid}, 8'd0);
        check({tag, "_in_ready"}, {7'b0, in_ready}, 8'd1);
    endtask

    // ---- directed sequence --------------------------------------------------
    initial begin
        logic signed [4:0] mix[8];
        mix = '{5'sd15, -5'sd16, 5'sd3, -5'sd1, 5'sd0, 5'sd7, -5'sd8, 5'sd2};

        rst       = 1'b1;
        sum_in    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        check_reset_outputs("rst_init");
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // +1 x8: total 8, max = min = 1 (ties keep value)
        send_block(5'sd1);
        collect(0);

        // -16 x8: total -128, stalled two cycles
        send_block(-5'sd16);
        collect(2);

        // mixed extremes, stalled five cycles with in_valid pulsing
        for (int i = 0; i < N; i++) send(mix[i], 1'b1);
        collect(5);

        // asynchronous reset after four transfers discards the partial block
        for (int i = 0; i < 4; i++) send(5'sd5, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // +2 x8 from a fresh count: total 16
        send_block(5'sd2);
        collect(1);

        // +3 with in_valid toggling every other cycle: total 24
        for (int i = 0; i < N; i++) begin
            send(5'sd3, 1'b1);
            if (i != N - 1) send(-5'sd9, 1'b0);
        end
        collect(0);

        // random block with out_ready held high while accumulating
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            send(5'($urandom_range(31, 0)), 1'b1);
            out_ready = 1'b1;
        end
        collect($urandom_range(3, 0));

        // back-to-back block: one HOLD cycle must separate blocks
        send_block(-5'sd1);
        collect(0);

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sum_accum5.md
SUM_ACCUM5 -- requirements
Module: sum_accum5

Interface
REQ-001 SHALL have parameter N, default 8, meaning samples per block; legal range 2..8.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port sum_in  input  5  signed two's-complement sample, driven by the 5-bit signed adder's sum.
REQ-005 SHALL have port in_valid  input  1  sum_in carries a sample this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-007 SHALL have port acc_out  output  8  signed total of the last completed block.
REQ-008 SHALL have port max_out  output  5  signed maximum sample of the last completed block.
REQ-009 SHALL have port min_out  output  5  signed minimum sample of the last completed block.
REQ-010 SHALL have port out_valid  output  1  block result is presented.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result this cycle.

Function
REQ-012 SHALL implement two states: ACCUM (collecting samples) and HOLD (presenting a result).
REQ-013 SHALL drive in_ready as a Moore output: 1 in ACCUM, 0 in HOLD.
REQ-014 SHALL count an input transfer only on a rising edge with in_valid=1 and in_ready=1; in_valid while in_ready=0 is ignored and the sample is not consumed.
REQ-015 SHALL, on each transfer, add sign-extended sum_in to an internal 8-bit accumulator and increment a sample counter.
REQ-016 SHALL load the internal running max/min directly from the first sample of a block, then update them with a signed compare on later samples (ties keep the value).
REQ-017 SHALL, on the edge of the Nth transfer, register the final total, max and min into acc_out/max_out/min_out, set out_valid=1, clear the accumulator and counter, and enter HOLD.
REQ-018 SHALL therefore assert out_valid in the cycle immediately after the Nth transfer edge (latency one clock).
REQ-019 SHALL hold acc_out, max_out, min_out and out_valid stable in HOLD until a rising edge with out_valid=1 and out_ready=1.
REQ-020 SHALL, on that handshake edge, clear out_valid and return to ACCUM; the data outputs retain their values until the next block completes.
REQ-021 SHALL ignore out_ready while out_valid=0.
REQ-022 SHALL insert at least one non-accepting cycle (HOLD) between blocks, even with out_ready held at 1.
REQ-023 SHALL need no overflow handling, because the 8-bit range covers N*(-16) through N*15 for N<=8; the arithmetic is exact.
REQ-024 SHALL tolerate gaps in in_valid without affecting the result; only transfers are counted.

Reset
REQ-025 SHALL, while rst=1, immediately and without a clock edge force state=ACCUM, the accumulator, counter and running max/min to 0, and acc_out=0, max_out=0, min_out=0, out_valid=0, in_ready=1.
REQ-026 SHALL discard a partial block when reset is asserted mid-block; the next block starts from count 0.
REQ-027 SHALL resume normal operation on the first rising edge after rst deasserts.

Verification
REQ-028 SHALL pass this scenario: reset, then 8 back-to-back transfers of +1 -> one clock after the 8th edge, out_valid=1, acc_out=8'h08, max_out=min_out=5'h01.
REQ-029 SHALL pass this scenario: 8 transfers of -16 (5'b10000) -> acc_out=8'h80 (-128), max_out=min_out=5'b10000.
REQ-030 SHALL pass this scenario: transfers of 15,-16,3,-1,0,7,-8,2 -> acc_out=8'h02, max_out=5'b01111, min_out=5'b10000.
REQ-031 SHALL pass this scenario: result presented with out_ready=0 for 5 cycles while in_valid pulses -> in_ready=0, outputs stable, no sample consumed; out_ready=1 -> out_valid=0 and in_ready=1 after that edge.
REQ-032 SHALL pass this scenario: rst pulsed asynchronously after 4 transfers -> outputs 0 without a clock edge; then 8 transfers of +2 -> acc_out=8'h10.
REQ-033 SHALL pass this scenario: 8 samples of +3 with in_valid toggling every other cycle -> acc_out=8'h18, out_valid only after the 8th actual transfer.
